// File: rtl/md_issue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_issue_if : request/response and MD-facing signal bundle for md_issue
// Rev 1.0
// ---------------------------------------------------------------------------
interface md_issue_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        div_zero;
    logic [1:0]  MDOp;
    logic [1:0]  MDWrite;
    logic        CalcuSigned;
    logic [31:0] RData1;
    logic [31:0] RData2;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, resp_ready, Busy, HI, LO,
        output req_ready, resp_valid, resp_data, div_zero,
               MDOp, MDWrite, CalcuSigned, RData1, RData2
    );

    modport master (
        output req_valid, req_op, req_rs, req_rt, resp_ready, Busy, HI, LO,
        input  req_ready, resp_valid, resp_data, div_zero,
               MDOp, MDWrite, CalcuSigned, RData1, RData2
    );
endinterface
`default_nettype wire

// File: rtl/md_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_issue : in-order HI/LO instruction issue controller in front of the MD
// Rev 1.0
// ---------------------------------------------------------------------------
module md_issue (
    input  logic        clk,
    input  logic        reset,
    md_issue_if.slave   md_if
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        div_zero_q, div_zero_d;

    logic        req_ready;
    logic        resp_valid;
    logic [1:0]  md_op;
    logic [1:0]  md_write;
    logic        calc_signed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            rs_q        <= 32'd0;
            rt_q        <= 32'd0;
            resp_data_q <= 32'd0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            resp_data_q <= resp_data_d;
            div_zero_q  <= div_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        resp_data_d = resp_data_q;
        div_zero_d  = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        md_op       = 2'b00;
        md_write    = 2'b00;
        calc_signed = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (md_if.req_valid) begin
                    op_d = md_if.req_op;
                    rs_d = md_if.req_rs;
                    rt_d = md_if.req_rt;
                    // Divide by zero is swallowed here so the MD never sees it.
                    if (md_if.req_op[2:1] == 2'b01 && md_if.req_rt == 32'd0) begin
                        div_zero_d = 1'b1;
                    end else if (md_if.req_op[2:1] == 2'b11) begin
                        state_d = READ;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                calc_signed = (op_q == 3'd0) || (op_q == 3'd2);
                if (!md_if.Busy) begin
                    case (op_q)
                        3'd0, 3'd1: md_op    = 2'b01;
                        3'd2, 3'd3: md_op    = 2'b10;
                        3'd4:       md_write = 2'b01;
                        3'd5:       md_write = 2'b10;
                        default:    md_op    = 2'b00;
                    endcase
                    state_d = IDLE;
                end
            end
            READ: begin
                // HI/LO are already final in the first cycle Busy is low.
                if (!md_if.Busy) begin
                    resp_data_d = op_q[0] ? md_if.LO : md_if.HI;
                    state_d     = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (md_if.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign md_if.req_ready   = req_ready;
    assign md_if.resp_valid  = resp_valid;
    assign md_if.resp_data   = resp_data_q;
    assign md_if.div_zero    = div_zero_q;
    assign md_if.MDOp        = md_op;
    assign md_if.MDWrite     = md_write;
    assign md_if.CalcuSigned = calc_signed;
    assign md_if.RData1      = rs_q;
    assign md_if.RData2      = rt_q;
endmodule
`default_nettype wire

// File: tb/tb_md_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_md_issue : scoreboard bench for md_issue with a behavioural MD model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_md_issue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_issue_if bus();
    md_issue dut (.clk(clk), .reset(reset), .md_if(bus.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural result of an MD op, returned as {HI, LO}
    function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        logic signed [31:0] sa, sb;
        md_calc = 64'd0;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; md_calc = ea * eb; end
            3'd1: begin ea = {32'd0, a}; eb = {32'd0, b}; md_calc = ea * eb; end
            3'd2: if (b != 32'd0) md_calc = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b != 32'd0) md_calc = {a % b, a / b};
            default: md_calc = 64'd0;
        endcase
    endfunction

    // Behavioural MD: samples a command when idle, busy 6 (mul) / 11 (div) cycles
    int          md_cnt = 0;
    logic [31:0] md_hi = 32'd0, md_lo = 32'd0, pend_hi = 32'd0, pend_lo = 32'd0;
    assign bus.Busy = (md_cnt != 0);
    assign bus.HI   = md_hi;
    assign bus.LO   = md_lo;

    always @(posedge clk) begin
        if (md_cnt != 0) begin
            md_cnt <= md_cnt - 1;
            if (md_cnt == 1) begin
                md_hi <= pend_hi;
                md_lo <= pend_lo;
            end
        end else if (bus.MDOp != 2'b00) begin
            {pend_hi, pend_lo} <= md_calc((bus.MDOp == 2'b01) ? {2'b00, ~bus.CalcuSigned}
                                                              : {2'b01, ~bus.CalcuSigned},
                                          bus.RData1, bus.RData2);
            md_cnt <= (bus.MDOp == 2'b01) ? 6 : 11;
        end else if (bus.MDWrite == 2'b01) begin
            md_hi <= bus.RData1;
        end else if (bus.MDWrite == 2'b10) begin
            md_lo <= bus.RData1;
        end
    end

    logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;
    logic [31:0] exp_q[$];

    int   n_mul = 0, n_div = 0, n_wr = 0, n_resp = 0;
    logic last_signed = 1'b0;
    logic prev_busy = 1'b0, prev_rv = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (bus.MDOp != 2'b00 || bus.MDWrite != 2'b00) begin
            chk_eq("md_cmd_while_busy", 32'(bus.Busy), 32'd0);
            if (bus.MDOp == 2'b01) n_mul++;
            if (bus.MDOp == 2'b10) n_div++;
            if (bus.MDWrite != 2'b00) n_wr++;
            last_signed = bus.CalcuSigned;
        end
        if (bus.resp_valid && !prev_rv)
            chk_eq("resp_before_busy_fall", 32'(prev_busy), 32'd0);
        if (bus.resp_valid && bus.resp_ready) begin
            n_resp++;
            if (exp_q.size() == 0) chk_eq("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
            else                   chk_eq("resp_data", bus.resp_data, exp_q.pop_front());
        end
        prev_busy = bus.Busy;
        prev_rv   = bus.resp_valid;
    end

    // Call at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk_eq("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        case (op)
            3'd0, 3'd1: {ref_hi, ref_lo} = md_calc(op, rs, rt);
            3'd2, 3'd3: if (rt != 32'd0) {ref_hi, ref_lo} = md_calc(op, rs, rt);
            3'd4: ref_hi = rs;
            3'd5: ref_lo = rs;
            3'd6: exp_q.push_back(ref_hi);
            default: exp_q.push_back(ref_lo);
        endcase
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.Busy || bus.resp_valid || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk_eq({pfx, "_req_ready"},  32'(bus.req_ready),   32'd1);
        chk_eq({pfx, "_resp_valid"}, 32'(bus.resp_valid),  32'd0);
        chk_eq({pfx, "_resp_data"},  bus.resp_data,        32'd0);
        chk_eq({pfx, "_div_zero"},   32'(bus.div_zero),    32'd0);
        chk_eq({pfx, "_MDOp"},       32'(bus.MDOp),        32'd0);
        chk_eq({pfx, "_MDWrite"},    32'(bus.MDWrite),     32'd0);
        chk_eq({pfx, "_CalcuSigned"},32'(bus.CalcuSigned), 32'd0);
        chk_eq({pfx, "_RData1"},     bus.RData1,           32'd0);
        chk_eq({pfx, "_RData2"},     bus.RData2,           32'd0);
    endtask

    initial begin
        int b_mul, b_div, b_wr, b_resp, n;
        logic [31:0] held;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_rs     = 32'd0;
        bus.req_rt     = 32'd0;
        bus.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply followed by both reads
        b_mul = n_mul;
        send(3'd0, 32'd3, 32'hFFFF_FFFC);
        send(3'd7, 32'd0, 32'd0);
        send(3'd6, 32'd0, 32'd0);
        wait_idle();
        chk_eq("mult_issue_count", 32'(n_mul - b_mul), 32'd1);
        chk_eq("mult_signed", 32'(last_signed), 32'd1);

        // Unsigned divide
        b_div = n_div;
        send(3'd3, 32'd7, 32'd2);
        send(3'd6, 32'd0, 32'd0);
        send(3'd7, 32'd0, 32'd0);
        wait_idle();
        chk_eq("divu_issue_count", 32'(n_div - b_div), 32'd1);
        chk_eq("divu_signed", 32'(last_signed), 32'd0);

        // Divide by zero is trapped
        b_div = n_div;
        send(3'd2, 32'd9, 32'd0);
        chk_eq("divz_pulse", 32'(bus.div_zero), 32'd1);
        chk_eq("divz_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk_eq("divz_pulse_end", 32'(bus.div_zero), 32'd0);
        send(3'd7, 32'd0, 32'd0);
        wait_idle();
        chk_eq("divz_no_issue", 32'(n_div - b_div), 32'd0);

        // MTLO right behind a MULT waits for Busy to fall
        b_wr = n_wr;
        send(3'd0, 32'd5, 32'd6);
        send(3'd5, 32'h0000_1234, 32'd0);
        n = 0;
        while (bus.Busy && n < 50) begin
            chk_eq("mtlo_req_ready", 32'(bus.req_ready), 32'd0);
            chk_eq("mtlo_wait_no_write", 32'(bus.MDWrite), 32'd0);
            @(negedge clk);
            n++;
        end
        chk_eq("mtlo_write", 32'(bus.MDWrite), 32'd2);
        @(negedge clk);
        send(3'd7, 32'd0, 32'd0);
        wait_idle();
        chk_eq("mtlo_write_count", 32'(n_wr - b_wr), 32'd1);

        // Response back-pressure
        bus.resp_ready = 1'b0;
        send(3'd6, 32'd0, 32'd0);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = bus.resp_data;
        repeat (5) begin
            chk_eq("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk_eq("stall_resp_data", bus.resp_data, held);
            chk_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk_eq("stall_release_idle", 32'(bus.req_ready), 32'd1);
        chk_eq("stall_release_valid", 32'(bus.resp_valid), 32'd0);
        wait_idle();

        // Reset while an MFHI waits in READ behind a DIV
        send(3'd2, 32'd100, 32'd7);
        send(3'd6, 32'd0, 32'd0);
        chk_eq("read_not_ready", 32'(bus.req_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        b_resp = n_resp;
        b_mul  = n_mul + n_div + n_wr;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("midrst_no_resp", 32'(n_resp - b_resp), 32'd0);
        chk_eq("midrst_no_cmd", 32'(n_mul + n_div + n_wr - b_mul), 32'd0);
        wait_idle();
        send(3'd6, 32'd0, 32'd0);
        wait_idle();

        // MTHI then MFHI
        send(3'd4, 32'h0000_ABCD, 32'd0);
        send(3'd6, 32'd0, 32'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
